// File: rtl/alu_sequencer_if.sv
// Register-file port of the ALU sequencer: a single-port array with a
// one-cycle read latency. The sequencer is the master and the array is the slave.
interface alu_sequencer_if;
  logic [7:0] rf_addr;
  logic       rf_re;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [7:0] rf_wdata;

  modport master (output rf_addr, rf_re, rf_we, rf_wdata, input rf_rdata);
  modport slave  (input rf_addr, rf_re, rf_we, rf_wdata, output rf_rdata);
endinterface

// File: rtl/alu_sequencer.sv
// Operand sequencer for the combinational Z8 ALU. It fetches operands from the register file,
// writes results back, owns FLAGS, and runs INCW/DECW and DA in two phases.
module alu_sequencer (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4:0]             op,
  input  logic [7:0]             dst,
  input  logic [7:0]             src,
  output logic                   busy,
  output logic                   done,
  alu_sequencer_if.master        rf,
  output logic [4:0]             alu_mode,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [7:0]             alu_flags,
  input  logic [7:0]             alu_out,
  input  logic [7:0]             alu_out_flags,
  output logic [7:0]             flags,
  input  logic                   flags_we,
  input  logic [7:0]             flags_wdata
);
  localparam logic [4:0] ALU2_ADD  = 5'h00, ALU2_ADC  = 5'h01, ALU2_SUB = 5'h02,
                         ALU2_SBC  = 5'h03, ALU2_OR   = 5'h04, ALU2_AND = 5'h05,
                         ALU2_TCM  = 5'h06, ALU2_TM   = 5'h07, ALU2_CP  = 5'h08,
                         ALU2_XOR  = 5'h09;
  localparam logic [4:0] ALU1_INC  = 5'h11, ALU1_DEC  = 5'h12, ALU1_DA  = 5'h13,
                         ALU1_DA_H = 5'h14, ALU1_INCW = 5'h15, ALU1_DECW = 5'h16;

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_LATA, S_LATB, S_EXEC, S_RDH, S_LATH, S_EXEC_H
  } state_t;

  state_t     state, state_nx;
  logic [4:0] op_q;
  logic [7:0] dst_q, src_q, op_a, op_b, tmp_flags;
  logic       is_two, is_nowb, is_word, is_daa, flags_upd;
  logic [7:0] dst_lo, dst_hi;
  logic [7:0] rf_addr, rf_wdata;
  logic       rf_re, rf_we;

  assign is_two  = op_q inside {ALU2_ADD, ALU2_ADC, ALU2_SUB, ALU2_SBC, ALU2_CP,
                                ALU2_OR, ALU2_AND, ALU2_TCM, ALU2_TM, ALU2_XOR};
  assign is_nowb = op_q inside {ALU2_CP, ALU2_TCM, ALU2_TM};
  assign is_word = op_q inside {ALU1_INCW, ALU1_DECW};
  assign is_daa  = (op_q == ALU1_DA);
  assign dst_lo  = dst_q | 8'h01;
  assign dst_hi  = dst_q & 8'hFE;
  assign busy    = (state != S_IDLE);

  assign rf.rf_addr  = rf_addr;
  assign rf.rf_re    = rf_re;
  assign rf.rf_we    = rf_we;
  assign rf.rf_wdata = rf_wdata;

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx  = state;
    done      = 1'b0;
    rf_addr   = 8'h00;
    rf_re     = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = 8'h00;
    alu_mode  = 5'h00;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_flags = 8'h00;
    flags_upd = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_RDA;
      S_RDA: begin
        rf_re    = 1'b1;
        rf_addr  = is_word ? dst_lo : dst_q;
        state_nx = S_LATA;
      end
      S_LATA: begin
        if (is_two) begin
          rf_re    = 1'b1;
          rf_addr  = src_q;
          state_nx = S_LATB;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_LATB: state_nx = S_EXEC;
      S_EXEC: begin
        alu_a     = op_a;
        alu_flags = flags;
        if (is_word) begin
          // Low byte goes through plain INC/DEC; FLAGS wait for the high phase.
          alu_mode = (op_q == ALU1_INCW) ? ALU1_INC : ALU1_DEC;
          rf_we    = 1'b1;
          rf_addr  = dst_lo;
          rf_wdata = alu_out;
          state_nx = S_RDH;
        end else if (is_daa) begin
          alu_mode = ALU1_DA;
          state_nx = S_EXEC_H;
        end else begin
          alu_mode  = op_q;
          alu_b     = is_two ? op_b : 8'h00;
          rf_we     = !is_nowb;
          rf_addr   = dst_q;
          rf_wdata  = alu_out;
          flags_upd = 1'b1;
          done      = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_RDH: begin
        rf_re    = 1'b1;
        rf_addr  = dst_hi;
        state_nx = S_LATH;
      end
      S_LATH: state_nx = S_EXEC_H;
      S_EXEC_H: begin
        alu_a     = op_a;
        rf_we     = 1'b1;
        rf_wdata  = alu_out;
        flags_upd = 1'b1;
        done      = 1'b1;
        state_nx  = S_IDLE;
        if (is_daa) begin
          alu_mode  = ALU1_DA_H;
          alu_flags = tmp_flags;
          rf_addr   = dst_q;
        end else begin
          alu_mode  = op_q;
          alu_b     = op_b;
          alu_flags = flags;
          rf_addr   = dst_hi;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= 5'h00;
      dst_q     <= 8'h00;
      src_q     <= 8'h00;
      op_a      <= 8'h00;
      op_b      <= 8'h00;
      tmp_flags <= 8'h00;
      flags     <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        op_q  <= op;
        dst_q <= dst;
        src_q <= src;
      end
      if (state == S_LATA || state == S_LATH) op_a <= rf.rf_rdata;
      if (state == S_LATB) op_b <= rf.rf_rdata;
      if (state == S_EXEC && is_word) op_b <= alu_out;
      if (state == S_EXEC && is_daa) begin
        op_a      <= alu_out;
        tmp_flags <= alu_out_flags;
      end
      // A sequencer result takes priority over an external FLAGS load in the same cycle.
      if (flags_upd)     flags <= alu_out_flags;
      else if (flags_we) flags <= flags_wdata;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer. It uses a behavioural Z8 ALU, a register-file model,
// a table of single ops, and hand-written word/DA, reset and priority sequences.
module tb_alu_sequencer;
  localparam logic [4:0] ALU2_ADD  = 5'h00, ALU2_ADC  = 5'h01, ALU2_SUB = 5'h02,
                         ALU2_SBC  = 5'h03, ALU2_OR   = 5'h04, ALU2_AND = 5'h05,
                         ALU2_TCM  = 5'h06, ALU2_TM   = 5'h07, ALU2_CP  = 5'h08,
                         ALU2_XOR  = 5'h09;
  localparam logic [4:0] ALU1_COM  = 5'h10, ALU1_INC  = 5'h11, ALU1_DEC = 5'h12,
                         ALU1_DA   = 5'h13, ALU1_DA_H = 5'h14, ALU1_INCW = 5'h15,
                         ALU1_DECW = 5'h16;
  localparam int FC = 7, FZ = 6, FS = 5, FV = 4, FD = 3, FH = 2;

  logic       clk = 1'b0;
  logic       reset, start, busy, done, flags_we;
  logic [4:0] op, alu_mode;
  logic [7:0] dst, src, alu_a, alu_b, alu_flags, alu_out, alu_out_flags, flags, flags_wdata;

  always #5 clk = ~clk;

  alu_sequencer_if rf ();

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .dst(dst), .src(src),
    .busy(busy), .done(done), .rf(rf),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_flags(alu_flags),
    .alu_out(alu_out), .alu_out_flags(alu_out_flags),
    .flags(flags), .flags_we(flags_we), .flags_wdata(flags_wdata)
  );

  // Register file: registered read, write on the strobe, plus a bench preload port.
  logic [7:0] mem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (rf.rf_we) mem[rf.rf_addr] <= rf.rf_wdata;
    if (rf.rf_re) rf.rf_rdata <= mem[rf.rf_addr];
  end

  function automatic logic [15:0] alu_model(input logic [4:0] m, input logic [7:0] a, b, fl);
    logic [8:0] w;
    logic [4:0] h;
    logic [7:0] r, f;
    logic       cin;
    f   = fl;
    r   = a;
    cin = 1'b0;
    w   = 9'h000;
    h   = 5'h00;
    case (m)
      ALU2_ADD, ALU2_ADC: begin
        cin = (m == ALU2_ADC) ? fl[FC] : 1'b0;
        w = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        h = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, cin};
        r = w[7:0];
        f[FC] = w[8]; f[FH] = h[4]; f[FD] = 1'b0;
        f[FV] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      ALU2_SUB, ALU2_SBC, ALU2_CP: begin
        cin = (m == ALU2_SBC) ? fl[FC] : 1'b0;
        w = {1'b0, a} - {1'b0, b} - {8'h00, cin};
        h = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, cin};
        r = w[7:0];
        f[FC] = w[8];
        f[FV] = (a[7] != b[7]) && (r[7] != a[7]);
        if (m != ALU2_CP) begin f[FH] = h[4]; f[FD] = 1'b1; end
      end
      ALU2_AND: begin r = a & b;  f[FV] = 1'b0; end
      ALU2_OR:  begin r = a | b;  f[FV] = 1'b0; end
      ALU2_XOR: begin r = a ^ b;  f[FV] = 1'b0; end
      ALU2_TM:  begin r = a & b;  f[FV] = 1'b0; end
      ALU2_TCM: begin r = ~a & b; f[FV] = 1'b0; end
      ALU1_COM: begin r = ~a;     f[FV] = 1'b0; end
      ALU1_INC: begin r = a + 8'h01; f[FV] = (a == 8'h7F); end
      ALU1_DEC: begin r = a - 8'h01; f[FV] = (a == 8'h80); end
      ALU1_INCW: begin r = a + {7'h00, b == 8'h00}; f[FV] = (a == 8'h7F) && (b == 8'h00); end
      ALU1_DECW: begin r = a - {7'h00, b == 8'hFF}; f[FV] = (a == 8'h80) && (b == 8'hFF); end
      ALU1_DA: begin
        if (!fl[FD]) begin
          r = (fl[FH] || a[3:0] > 4'h9) ? a + 8'h06 : a;
          f[FC] = fl[FC] || (a > 8'h99);
        end else begin
          r = fl[FH] ? a - 8'h06 : a;
        end
      end
      ALU1_DA_H: r = fl[FC] ? (fl[FD] ? a - 8'h60 : a + 8'h60) : a;
      default: r = a;
    endcase
    f[FS] = r[7];
    if (m == ALU1_INCW || m == ALU1_DECW) f[FZ] = (r == 8'h00) && (b == 8'h00);
    else                                  f[FZ] = (r == 8'h00);
    return {r, f};
  endfunction

  always_comb {alu_out, alu_out_flags} = alu_model(alu_mode, alu_a, alu_b, alu_flags);

  int n_tests = 0, n_fail = 0, overlap = 0;
  int w_cyc [4];
  logic [7:0] w_addr [4];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1 pl_we = 1'b0;
  endtask

  task automatic set_flags(input logic [7:0] v);
    @(negedge clk); flags_we = 1'b1; flags_wdata = v;
    @(posedge clk); #1 flags_we = 1'b0;
  endtask

  // Entered just after the accept edge (cycle 1); returns the done cycle (0 on timeout).
  task automatic wait_done(output int cyc, output int wr);
    cyc = 0;
    wr  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rf.rf_re && rf.rf_we) overlap++;
      if (rf.rf_we) begin
        wr++;
        if (wr < 4) begin w_cyc[wr] = c; w_addr[wr] = rf.rf_addr; end
      end
      if (done) begin cyc = c; break; end
      @(posedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [4:0] o, input logic [7:0] d, input logic [7:0] s,
                        output int cyc, output int wr);
    @(negedge clk); op = o; dst = d; src = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(cyc, wr);
  endtask

  typedef struct {
    logic [4:0] op;
    logic [7:0] a, b, fin, res, fl;
    int         cyc, wr;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int cyc, wr;
    vecs[0]  = '{ALU2_ADD, 8'h3C, 8'h45, 8'h00, 8'h81, 8'h34, 4, 1};
    vecs[1]  = '{ALU2_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hC4, 4, 1};
    vecs[2]  = '{ALU2_ADC, 8'h7F, 8'h00, 8'h80, 8'h80, 8'h34, 4, 1};
    vecs[3]  = '{ALU2_SUB, 8'h05, 8'h06, 8'h00, 8'hFF, 8'hAC, 4, 1};
    vecs[4]  = '{ALU2_CP,  8'h05, 8'h05, 8'h00, 8'h05, 8'h40, 4, 0};
    vecs[5]  = '{ALU2_AND, 8'hF0, 8'h3C, 8'h80, 8'h30, 8'h80, 4, 1};
    vecs[6]  = '{ALU2_TM,  8'h0F, 8'hF0, 8'h00, 8'h0F, 8'h40, 4, 0};
    vecs[7]  = '{ALU2_XOR, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'h20, 4, 1};
    vecs[8]  = '{ALU1_INC, 8'h7F, 8'h00, 8'h00, 8'h80, 8'h30, 3, 1};
    vecs[9]  = '{ALU1_DEC, 8'h01, 8'h00, 8'h80, 8'h00, 8'hC0, 3, 1};
    vecs[10] = '{ALU1_COM, 8'h55, 8'h00, 8'h00, 8'hAA, 8'h20, 3, 1};
    vecs[11] = '{ALU1_DA,  8'h3C, 8'h00, 8'h00, 8'h42, 8'h00, 4, 1};
    vecs[12] = '{ALU1_DA,  8'h9A, 8'h00, 8'h00, 8'h00, 8'hC0, 4, 1};

    reset = 1'b1; start = 1'b0; flags_we = 1'b0; flags_wdata = 8'h00;
    op = 5'h00; dst = 8'h00; src = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {7'h0, busy}, 8'h00);
    check("reset_done", {7'h0, done}, 8'h00);
    check("reset_flags", flags, 8'h00);
    check("reset_rf_addr", rf.rf_addr, 8'h00);
    check("reset_rf_re", {7'h0, rf.rf_re}, 8'h00);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      poke(8'h10, vecs[i].a);
      poke(8'h20, vecs[i].b);
      set_flags(vecs[i].fin);
      run_op(vecs[i].op, 8'h10, 8'h20, cyc, wr);
      check($sformatf("vec%0d_done_cycle", i), 8'(cyc), 8'(vecs[i].cyc));
      check($sformatf("vec%0d_writes", i), 8'(wr), 8'(vecs[i].wr));
      check($sformatf("vec%0d_result", i), mem[8'h10], vecs[i].res);
      check($sformatf("vec%0d_flags", i), flags, vecs[i].fl);
    end

    // INCW with a low-byte carry into the high byte, dst given as the odd address.
    poke(8'h30, 8'h12); poke(8'h31, 8'hFF); set_flags(8'h00);
    run_op(ALU1_INCW, 8'h31, 8'h00, cyc, wr);
    check("incw1_done_cycle", 8'(cyc), 8'd6);
    check("incw1_writes", 8'(wr), 8'd2);
    check("incw1_low_cycle", 8'(w_cyc[1]), 8'd3);
    check("incw1_low_addr", w_addr[1], 8'h31);
    check("incw1_high_cycle", 8'(w_cyc[2]), 8'd6);
    check("incw1_high_addr", w_addr[2], 8'h30);
    check("incw1_r30", mem[8'h30], 8'h13);
    check("incw1_r31", mem[8'h31], 8'h00);
    check("incw1_flags", flags, 8'h00);

    // INCW wrapping the whole word to zero, dst given as the even address.
    poke(8'h30, 8'hFF); poke(8'h31, 8'hFF); set_flags(8'h00);
    run_op(ALU1_INCW, 8'h30, 8'h00, cyc, wr);
    check("incw2_r30", mem[8'h30], 8'h00);
    check("incw2_r31", mem[8'h31], 8'h00);
    check("incw2_flags", flags, 8'h40);

    // Reset in cycle 4 of a DECW leaves only the low-byte write behind.
    poke(8'h30, 8'h20); poke(8'h31, 8'h00); set_flags(8'h55);
    @(negedge clk); op = ALU1_DECW; dst = 8'h30; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_decw_busy", {7'h0, busy}, 8'h00);
    check("rst_decw_flags", flags, 8'h00);
    check("rst_decw_rf_we", {7'h0, rf.rf_we}, 8'h00);
    @(negedge clk); reset = 1'b0;
    check("rst_decw_r31", mem[8'h31], 8'hFF);
    check("rst_decw_r30", mem[8'h30], 8'h20);

    // Start held high across an ADD, with an external FLAGS write colliding with its EXEC.
    poke(8'h10, 8'h3C); poke(8'h20, 8'h45); set_flags(8'h00);
    @(negedge clk); op = ALU2_ADD; dst = 8'h10; src = 8'h20; start = 1'b1;
    @(posedge clk); #1 op = ALU2_CP;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("prio_done_c4", {7'h0, done}, 8'h01);
    flags_we = 1'b1; flags_wdata = 8'h80;
    @(posedge clk); #1 flags_we = 1'b0;
    check("prio_flags", flags, 8'h34);
    check("prio_idle_c5", {7'h0, busy}, 8'h00);
    @(posedge clk); #1;
    check("prio_restart_c6", {7'h0, busy}, 8'h01);
    start = 1'b0;
    wait_done(cyc, wr);
    check("prio_cp_done_cycle", 8'(cyc), 8'd4);
    check("prio_cp_writes", 8'(wr), 8'd0);
    check("prio_cp_flags", flags, 8'h14);
    check("prio_r10", mem[8'h10], 8'h81);

    check("rf_re_we_overlap", 8'(overlap), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle operand sequencer sitting directly upstream of the combinational Z8 ALU. It accepts one ALU operation request at a time and reads operands from the single-port register file. It drives the ALU's mode/a/b/flags inputs, writes the result back, and owns the architectural FLAGS register. It handles the two-phase operations itself: INCW/DECW (low byte, then high byte) and DA (ALU1_DA, then ALU1_DA_H).

## Interface
- No parameters.
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request strobe; accepted only when busy=0
- op  in  5  ALU mode, alu.vh encoding (ALU1_*, ALU2_*)
- dst  in  8  register address of operand a and destination; word ops use dst&8'hFE as high byte, dst|1 as low byte
- src  in  8  register address of operand b (ALU2_* only)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse in final execute cycle
- rf_addr  out  8  register-file address
- rf_re  out  1  read strobe; rf_rdata valid the following cycle
- rf_rdata  in  8  read data
- rf_we  out  1  write strobe (same cycle as rf_addr/rf_wdata)
- rf_wdata  out  8  write data
- alu_mode  out  5, alu_a  out  8, alu_b  out  8, alu_flags  out  8  ALU inputs
- alu_out  in  8, alu_out_flags  in  8  ALU results
- flags  out  8  FLAGS register (flags.vh bit indices)
- flags_we  in  1, flags_wdata  in  8  external FLAGS write

## Operation
- Op classes:
  - TWO: ALU2_ADD/ADC/SUB/SBC/CP/OR/AND/TCM/TM/XOR.
  - NOWB (flags only, no rf write): CP, TCM, TM.
  - WORD: ALU1_INCW, ALU1_DECW.
  - DAA: ALU1_DA.
  - Every other code is ONE (single operand, read dst).
- States:
  - IDLE
  - RDA (rf_re, rf_addr=dst or dst|1 for WORD)
  - LATA (latch rf_rdata into opA; for TWO also rf_re, rf_addr=src)
  - LATB (latch rf_rdata into opB)
  - EXEC
  - RDH (rf_re, rf_addr=dst&FE)
  - LATH (opA<=rf_rdata)
  - EXEC_H
- Transitions:
  - ONE: IDLE→RDA→LATA→EXEC→IDLE.
  - TWO: IDLE→RDA→LATA→LATB→EXEC→IDLE.
  - WORD: IDLE→RDA→LATA→EXEC→RDH→LATH→EXEC_H→IDLE.
  - DAA: IDLE→RDA→LATA→EXEC→EXEC_H→IDLE.
- EXEC:
  - alu_mode=op, alu_a=opA, alu_b=opB (0 for ONE), alu_flags=flags.
  - ONE/TWO: rf_we=1 unless NOWB; rf_addr=dst; rf_wdata=alu_out; flags<=alu_out_flags; done=1.
  - WORD: alu_mode=ALU1_INC (INCW) or ALU1_DEC (DECW); write low byte at dst|1; opB<=alu_out; flags NOT updated.
  - DAA: alu_mode=ALU1_DA; opA<=alu_out; tmpFlags<=alu_out_flags; no write.
- EXEC_H:
  - WORD: alu_mode=op, alu_a=opA (high byte), alu_b=opB (new low byte), alu_flags=flags; write high byte at dst&FE; flags<=alu_out_flags; done=1.
  - DAA: alu_mode=ALU1_DA_H, alu_a=opA, alu_flags=tmpFlags; write dst; flags<=alu_out_flags; done=1.
- busy=1 in every non-IDLE state; start while busy is ignored; op/dst/src are registered at acceptance.
- FLAGS write priority: a sequencer update wins over flags_we in the same cycle. Otherwise flags_we loads flags_wdata in any state. An op started in the same cycle as flags_we sees the new value.
- Arithmetic: all 8-bit, wrap-around; no carry kept between ops except via FLAGS.

## Timing
- start sampled high with busy=0 in cycle 0; RDA is cycle 1.
- done cycle:
  - ONE: 3
  - TWO: 4
  - DAA: 4
  - WORD: 6 (low write in cycle 3, high write in cycle 6)
- IDLE follows done; a new start is accepted in the cycle after done, so back-to-back ops have no gap beyond the one IDLE cycle.
- rf_re and rf_we are never both high. Read and write addresses never overlap within one cycle.
- Reset (async, any state):
  - State→IDLE.
  - busy, done, rf_re, rf_we = 0.
  - rf_addr, rf_wdata, alu_mode, alu_a, alu_b, alu_flags, flags, opA, opB, tmpFlags = 0.
  - A WORD op interrupted after cycle 3 leaves only the low byte written.

## Test plan
- ADD: R10=3C, R20=45, flags=00, op=ALU2_ADD, dst=10, src=20 → done at cycle 4; R10=81; flags: S=1, V=1, H=1, C=0, Z=0, D=0.
- INCW: R30=12, R31=FF, dst=31 → R31=00 written at cycle 3, R30=13 at cycle 6, Z=0. Repeat with R30=FF, R31=FF → R30=00, R31=00, Z=1.
- DA: flags C=0 H=0 D=0, R40=3C, op=ALU1_DA → R40=42, C=0, done at cycle 4; only one rf_we pulse.
- CP: R10=05, R20=05, op=ALU2_CP → Z=1, C=0; rf_we never asserted; R10 unchanged.
- Reset during DECW at cycle 4 (R30=20, R31=00) → R31=FF written, R30 stays 20; busy=0 and flags=00 immediately after reset.
- start held high during a TWO op, then flags_we=1 (wdata=80) in the EXEC cycle → second op accepted only after done; flags equal the ALU result, not 80.
